// File: rtl/tl_tx_queue_if.sv
// Transaction-layer push side and PHY-facing data/status bundle for tl_tx_queue.
// master = transaction layer / PHY side; slave = the queue itself.
interface tl_tx_queue_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  push;
  logic [DATA_WIDTH-1:0] data_wr;
  logic                  pause;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic [1:0]            state;
  logic [15:0]           sent_count;

  modport master (
    output push, data_wr, pause,
    input  data_out, valid, full, empty, almost_full, almost_empty,
           overflow, state, sent_count
  );

  modport slave (
    input  push, data_wr, pause,
    output data_out, valid, full, empty, almost_full, almost_empty,
           overflow, state, sent_count
  );
endinterface

// File: rtl/tl_tx_queue.sv
// 8-deep transmit queue feeding the PHY; a word pushed at edge N leaves after edge N+1.
// pause holds the head word in place (idle filler sent); pushes while full are dropped and flagged.
module tl_tx_queue #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 3,
  parameter int                    AF_THRESH  = 6,
  parameter int                    AE_THRESH  = 2,
  parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = 32'hBCBCBCBC
) (
  input  logic          clock1,
  input  logic          reset_L,
  tl_tx_queue_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  almost_full_q, almost_full_d;
  logic                  almost_empty_q, almost_empty_d;
  logic                  overflow_q, overflow_d;
  logic [15:0]           sent_count_q, sent_count_d;

  logic                  push_acc;
  logic                  pop_en;

  // Full is the registered flag, so a push while full is dropped even if a pop frees a slot.
  always_comb begin
    push_acc       = bus.push && !full_q;
    pop_en         = (count_q != '0) && !bus.pause;

    mem_d          = mem_q;
    if (push_acc) begin
      mem_d[wr_ptr_q] = bus.data_wr;
    end

    wr_ptr_d       = wr_ptr_q + ADDR_WIDTH'(push_acc);
    rd_ptr_d       = rd_ptr_q + ADDR_WIDTH'(pop_en);
    count_d        = count_q + CW'(push_acc) - CW'(pop_en);

    data_out_d     = pop_en ? mem_q[rd_ptr_q] : IDLE_WORD;
    valid_d        = pop_en;
    sent_count_d   = sent_count_q + 16'(pop_en);
    overflow_d     = overflow_q || (bus.push && full_q);

    full_d         = (count_d == CW'(DEPTH));
    empty_d        = (count_d == '0);
    almost_full_d  = (count_d >= CW'(AF_THRESH));
    almost_empty_d = (count_d <= CW'(AE_THRESH));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (count_d != '0) begin
          state_d = bus.pause ? ST_PAUSE : ST_SEND;
        end
      end
      ST_SEND: begin
        if (count_d == '0) begin
          state_d = ST_IDLE;
        end else if (bus.pause) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (!bus.pause) begin
          state_d = ST_SEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock1) begin
    if (!reset_L) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Storage needs no reset: pointers and count decide which entries are live.
  always_ff @(posedge clock1) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clock1) begin
    if (!reset_L) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      data_out_q     <= IDLE_WORD;
      valid_q        <= 1'b0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      sent_count_q   <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      data_out_q     <= data_out_d;
      valid_q        <= valid_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      sent_count_q   <= sent_count_d;
    end
  end

  always_comb begin
    bus.state        = state_q;
    bus.data_out     = data_out_q;
    bus.valid        = valid_q;
    bus.full         = full_q;
    bus.empty        = empty_q;
    bus.almost_full  = almost_full_q;
    bus.almost_empty = almost_empty_q;
    bus.overflow     = overflow_q;
    bus.sent_count   = sent_count_q;
  end

endmodule

// File: tb/tb_tl_tx_queue.sv
// Directed bench for tl_tx_queue: expected words queued at push time, popped by a negedge monitor.
module tb_tl_tx_queue;

  localparam logic [31:0] IDLE = 32'hBCBCBCBC;

  logic clock1;
  logic reset_L;

  tl_tx_queue_if #(.DATA_WIDTH(32)) bus ();

  tl_tx_queue dut (
    .clock1  (clock1),
    .reset_L (reset_L),
    .bus     (bus)
  );

  int          n_vec;
  int          n_err;
  logic        mon_en;
  logic [31:0] exp_q [$];

  initial clock1 = 1'b0;
  always #5 clock1 = ~clock1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock1);
    #1;
  endtask

  task automatic do_reset(input int edges);
    reset_L  = 1'b0;
    bus.push = 1'b0;
    bus.pause = 1'b0;
    repeat (edges) tick();
    exp_q.delete();
    reset_L = 1'b1;
  endtask

  task automatic push_word(input logic [31:0] w, input bit expect_out);
    bus.push    = 1'b1;
    bus.data_wr = w;
    if (expect_out) exp_q.push_back(w);
  endtask

  // Scoreboard monitor: every valid word must be the oldest expected one; idle cycles carry filler.
  always @(negedge clock1) begin
    if (mon_en) begin
      if (bus.valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", bus.data_out, 32'hxxxxxxxx);
        end else begin
          chk("word_order", bus.data_out, exp_q.pop_front());
        end
      end else begin
        chk("idle_filler", bus.data_out, IDLE);
      end
    end
  end

  initial begin
    n_vec       = 0;
    n_err       = 0;
    mon_en      = 1'b0;
    reset_L     = 1'b0;
    bus.push    = 1'b0;
    bus.pause   = 1'b0;
    bus.data_wr = '0;

    // Reset with push held high
    bus.push    = 1'b1;
    bus.data_wr = 32'hDEADBEEF;
    tick();
    mon_en = 1'b1;
    tick();
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_data", bus.data_out, IDLE);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_aempty", 32'(bus.almost_empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_sent", 32'(bus.sent_count), 32'd0);
    chk("rst_state", 32'(bus.state), 32'd0);
    bus.push = 1'b0;
    reset_L  = 1'b1;
    tick();
    chk("rst_push_ignored", 32'(bus.empty), 32'd1);

    // Single word
    push_word(32'h12345678, 1'b1);
    tick();
    chk("single_state_send", 32'(bus.state), 32'd1);
    bus.push = 1'b0;
    tick();
    chk("single_valid", 32'(bus.valid), 32'd1);
    chk("single_sent", 32'(bus.sent_count), 32'd1);
    tick();
    chk("single_valid_off", 32'(bus.valid), 32'd0);
    chk("single_state_idle", 32'(bus.state), 32'd0);

    // Fill under pause, overflow, then drain
    do_reset(1);
    bus.pause = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      push_word(32'(i), i <= 8);
      tick();
      if (i == 2) chk("fill_aempty2", 32'(bus.almost_empty), 32'd1);
      if (i == 3) chk("fill_aempty3", 32'(bus.almost_empty), 32'd0);
      if (i == 5) chk("fill_afull5", 32'(bus.almost_full), 32'd0);
      if (i == 6) chk("fill_afull6", 32'(bus.almost_full), 32'd1);
      if (i == 7) chk("fill_full7", 32'(bus.full), 32'd0);
      if (i == 8) chk("fill_full8", 32'(bus.full), 32'd1);
      if (i == 8) chk("fill_ovf8", 32'(bus.overflow), 32'd0);
      if (i == 9) chk("fill_ovf9", 32'(bus.overflow), 32'd1);
    end
    chk("fill_state_pause", 32'(bus.state), 32'd2);
    chk("fill_valid_paused", 32'(bus.valid), 32'd0);
    bus.push  = 1'b0;
    bus.pause = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("drain_valid", 32'(bus.valid), 32'd1);
    end
    tick();
    chk("drain_done", 32'(bus.valid), 32'd0);
    chk("drain_sent", 32'(bus.sent_count), 32'd8);
    chk("drain_ovf_sticky", 32'(bus.overflow), 32'd1);
    chk("drain_empty", 32'(bus.empty), 32'd1);
    chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);

    // Pause mid-burst: A, idle, idle, B, C
    do_reset(1);
    push_word(32'hAAAA0001, 1'b1);
    tick();
    chk("pm_state1", 32'(bus.state), 32'd1);
    push_word(32'hBBBB0002, 1'b1);
    tick();
    chk("pm_state2", 32'(bus.state), 32'd1);
    chk("pm_valid_a", 32'(bus.valid), 32'd1);
    push_word(32'hCCCC0003, 1'b1);
    bus.pause = 1'b1;
    tick();
    chk("pm_state3", 32'(bus.state), 32'd2);
    chk("pm_valid_p1", 32'(bus.valid), 32'd0);
    bus.push = 1'b0;
    tick();
    chk("pm_state4", 32'(bus.state), 32'd2);
    chk("pm_valid_p2", 32'(bus.valid), 32'd0);
    bus.pause = 1'b0;
    tick();
    chk("pm_state5", 32'(bus.state), 32'd1);
    chk("pm_valid_b", 32'(bus.valid), 32'd1);
    tick();
    chk("pm_state6", 32'(bus.state), 32'd0);
    chk("pm_valid_c", 32'(bus.valid), 32'd1);
    tick();
    chk("pm_valid_end", 32'(bus.valid), 32'd0);

    // Streaming with wrap: push every cycle, continuous output after one cycle
    do_reset(1);
    for (int i = 1; i <= 20; i++) begin
      push_word(32'h0000_0100 + 32'(i), 1'b1);
      tick();
      if (i >= 2) chk("stream_valid", 32'(bus.valid), 32'd1);
      if (i == 10) chk("stream_not_empty", 32'(bus.empty), 32'd0);
      if (i == 10) chk("stream_aempty", 32'(bus.almost_empty), 32'd1);
    end
    bus.push = 1'b0;
    tick();
    chk("stream_last_valid", 32'(bus.valid), 32'd1);
    chk("stream_sent", 32'(bus.sent_count), 32'd20);
    tick();
    chk("stream_empty", 32'(bus.empty), 32'd1);
    chk("stream_ovf", 32'(bus.overflow), 32'd0);
    chk("stream_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-operation discards queued words
    do_reset(1);
    bus.pause = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      push_word(32'hE000_0000 + 32'(i), 1'b1);
      tick();
    end
    chk("mid_aempty", 32'(bus.almost_empty), 32'd0);
    chk("mid_empty", 32'(bus.empty), 32'd0);
    do_reset(1);
    chk("mid_rst_empty", 32'(bus.empty), 32'd1);
    chk("mid_rst_valid", 32'(bus.valid), 32'd0);
    chk("mid_rst_sent", 32'(bus.sent_count), 32'd0);
    chk("mid_rst_aempty", 32'(bus.almost_empty), 32'd1);
    push_word(32'hCAFEF00D, 1'b1);
    tick();
    bus.push = 1'b0;
    tick();
    chk("mid_new_valid", 32'(bus.valid), 32'd1);
    chk("mid_new_sent", 32'(bus.sent_count), 32'd1);
    tick();
    chk("mid_new_done", 32'(bus.valid), 32'd0);
    chk("mid_new_empty", 32'(bus.empty), 32'd1);
    chk("mid_sb_empty", 32'(exp_q.size()), 32'd0);

    tick();
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
